dvp_yuyv_packer: RTL and testbench

Front-end capture stage that turns an 8-bit DVP-style camera byte stream (vsync/href framing, qualified by a byte strobe) into the 32-bit packed YUYV words consumed by `yuyv_to_rgb`. It assembles four bytes per word, tracks line and frame position, and drops malformed data. Its `data_valid`/`yuyv_data` outputs connect directly to the `data_valid`/`yuyv_data` inputs of `yuyv_to_rgb`.

---
 rtl/dvp_pkg.sv | 38 +++
 rtl/dvp_yuyv_packer.sv | 154 +++++++++++++++
 tb/tb_dvp_yuyv_packer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP byte-stream front end.
// FSM states, YUYV byte lanes and per-line byte count helpers.
package dvp_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        IN_LINE,
        FRAME_END
    } state_t;

    // Byte lane index inside the packed 32-bit word, lane 3 = [31:24]
    localparam int LANE_Y0 = 3;
    localparam int LANE_U  = 2;
    localparam int LANE_Y1 = 1;
    localparam int LANE_V  = 0;

    localparam int IMG_WIDTH_DEF  = 320;
    localparam int BYTES_PER_LINE = 2 * IMG_WIDTH_DEF;

    function automatic int bytes_per_line(input int width);
        return 2 * width;
    endfunction

    function automatic logic [31:0] pack_word(
        input logic [23:0] hold,
        input logic [7:0]  last
    );
        logic [31:0] w;
        w = '0;
        w[LANE_Y0*8 +: 8] = hold[23:16];
        w[LANE_U*8  +: 8] = hold[15:8];
        w[LANE_Y1*8 +: 8] = hold[7:0];
        w[LANE_V*8  +: 8] = last;
        return w;
    endfunction

endpackage

// File: rtl/dvp_yuyv_packer.sv
// DVP capture: vsync/href framed byte stream to packed YUYV words.
// Tracks pixel position, flags short/long lines and extra lines.
module dvp_yuyv_packer
    import dvp_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 466
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        href,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        data_valid,
    output logic [31:0] yuyv_data,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_done,
    output logic        err_short,
    output logic        err_long
);

    localparam int BPL = bytes_per_line(IMG_WIDTH);
    localparam int CW  = 11;

    state_t          state;
    state_t          state_nx;
    logic            vsync_q;
    logic            vs_fall;
    logic            vs_rise;
    logic            line_start;
    logic            accept;
    logic            overflow;
    logic            line_end;
    logic            last_line;
    logic            full;
    logic            frame_closed;
    logic [CW-1:0]   byte_cnt;
    logic [CW-1:0]   cnt_cur;
    logic [1:0]      phase;
    logic [1:0]      ph_cur;
    logic [23:0]     hold;
    logic [9:0]      line_cnt;

    assign vs_fall    = vsync_q & ~vsync;
    assign vs_rise    = ~vsync_q & vsync;
    assign full       = (byte_cnt == CW'(BPL));
    assign last_line  = (line_cnt == 10'(IMG_HEIGHT - 1));
    assign cnt_cur    = line_start ? '0 : byte_cnt;
    assign ph_cur     = line_start ? 2'd0 : phase;
    assign frame_done = (state == FRAME_END);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle datapath controls
    always_comb begin
        state_nx   = state;
        line_start = 1'b0;
        accept     = 1'b0;
        overflow   = 1'b0;
        line_end   = 1'b0;
        unique case (state)
            WAIT_FRAME: begin
                if (vs_fall) state_nx = WAIT_LINE;
            end
            WAIT_LINE: begin
                if (vs_rise) begin
                    state_nx = WAIT_FRAME;
                end else if (href) begin
                    state_nx   = IN_LINE;
                    line_start = 1'b1;
                    accept     = byte_valid;
                end
            end
            IN_LINE: begin
                if (vs_rise) begin
                    state_nx = WAIT_FRAME;
                end else if (!href) begin
                    line_end = 1'b1;
                    state_nx = last_line ? FRAME_END : WAIT_LINE;
                end else if (byte_valid) begin
                    overflow = full;
                    accept   = ~full;
                end
            end
            FRAME_END: begin
                state_nx = WAIT_FRAME;
            end
            default: state_nx = WAIT_FRAME;
        endcase
    end

    // Byte assembly, position tracking and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            data_valid   <= 1'b0;
            yuyv_data    <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            frame_closed <= 1'b0;
            byte_cnt     <= '0;
            phase        <= '0;
            hold         <= '0;
            line_cnt     <= '0;
        end else begin
            vsync_q    <= vsync;
            data_valid <= 1'b0;
            if (state == WAIT_FRAME && vs_fall) begin
                line_cnt  <= '0;
                err_short <= 1'b0;
                err_long  <= 1'b0;
            end
            if (vs_rise) begin
                frame_closed <= 1'b0;
            end else if (state == FRAME_END) begin
                frame_closed <= 1'b1;
            end
            if (state == WAIT_FRAME && frame_closed && href && byte_valid) begin
                err_long <= 1'b1;
            end
            if (accept) begin
                byte_cnt <= cnt_cur + 1'b1;
                phase    <= ph_cur + 2'd1;
                hold     <= {hold[15:0], byte_data};
                if (ph_cur == 2'd3) begin
                    data_valid <= 1'b1;
                    yuyv_data  <= pack_word(hold, byte_data);
                    pixel_x    <= 10'(cnt_cur >> 1) & ~10'd1;
                    pixel_y    <= line_cnt;
                end
            end else if (line_start) begin
                byte_cnt <= '0;
                phase    <= '0;
            end
            if (overflow) err_long <= 1'b1;
            if (line_end) begin
                if (byte_cnt < CW'(BPL)) err_short <= 1'b1;
                line_cnt <= line_cnt + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_dvp_yuyv_packer.sv
// Scoreboard bench for dvp_yuyv_packer on a reduced frame size.
// Expected words come from the byte lists the stimulus sends.
module tb_dvp_yuyv_packer;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int BPL = 2 * W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        href;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        data_valid;
    logic [31:0] yuyv_data;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_done;
    logic        err_short;
    logic        err_long;

    dvp_yuyv_packer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .href       (href),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .data_valid (data_valid),
        .yuyv_data  (yuyv_data),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_done (frame_done),
        .err_short  (err_short),
        .err_long   (err_long)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fd_seen  = 0;
    int   fd_exp   = 0;
    int   m_line   = 0;
    bit   m_active = 0;
    bit   m_closed = 0;
    bit   exp_es   = 0;
    bit   exp_el   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected word on each strobe, count frame pulses
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (data_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h x=%0d y=%0d expected none",
                             yuyv_data, pixel_x, pixel_y);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("word_data", yuyv_data, e.d);
                    check("word_x", 32'(pixel_x), 32'(e.x));
                    check("word_y", 32'(pixel_y), 32'(e.y));
                end
            end
            if (frame_done) fd_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            href       = 1'b0;
            byte_valid = 1'($urandom_range(0, 1));
            byte_data  = 8'($urandom);
        end
    endtask

    task automatic check_flags();
        check("err_short", 32'(err_short), 32'(exp_es));
        check("err_long", 32'(err_long), 32'(exp_el));
        check("frame_done_count", 32'(fd_seen), 32'(fd_exp));
    endtask

    task automatic start_frame();
        @(negedge clk);
        vsync = 1'b1;
        idle(3);
        @(negedge clk);
        vsync = 1'b0;
        href  = 1'b0;
        idle(2);
        m_active = 1;
        m_closed = 0;
        m_line   = 0;
        exp_es   = 0;
        exp_el   = 0;
        check("err_short_cleared", 32'(err_short), 32'd0);
        check("err_long_cleared", 32'(err_long), 32'd0);
    endtask

    task automatic send_line(input int n, input bit gaps, input bit fixed);
        logic [7:0] b[$];
        logic [7:0] fb[4];
        logic [31:0] w;
        int sent;
        bit lat_done;
        fb[0] = 8'h10;
        fb[1] = 8'h80;
        fb[2] = 8'h20;
        fb[3] = 8'h90;
        sent = 0;
        lat_done = 0;
        while (sent < n) begin
            @(negedge clk);
            if (fixed && !lat_done && b.size() == 4) begin
                check("latency_valid", 32'(data_valid), 32'd1);
                check("first_word", yuyv_data, 32'h10802090);
                lat_done = 1;
            end
            href = 1'b1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = (fixed && sent < 4) ? fb[sent] : 8'($urandom);
                b.push_back(byte_data);
                sent++;
                if (m_active && b.size() % 4 == 0 && b.size() <= BPL) begin
                    w = {b[b.size()-4], b[b.size()-3],
                         b[b.size()-2], b[b.size()-1]};
                    q.push_back('{d: w,
                                  x: 10'(2 * (b.size() / 4 - 1)),
                                  y: 10'(m_line)});
                end
            end
        end
        @(negedge clk);
        href       = 1'b0;
        byte_valid = 1'b0;
        if (m_active) begin
            if (n < BPL) exp_es = 1;
            if (n > BPL) exp_el = 1;
            m_line++;
            if (m_line == H) begin
                fd_exp++;
                m_active = 0;
                m_closed = 1;
            end
        end else if (m_closed && n > 0) begin
            exp_el = 1;
        end
        idle(3);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_yuyv_data"}, yuyv_data, 32'd0);
        check({tag, "_pixel_x"}, 32'(pixel_x), 32'd0);
        check({tag, "_pixel_y"}, 32'(pixel_y), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_err_short"}, 32'(err_short), 32'd0);
        check({tag, "_err_long"}, 32'(err_long), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        vsync      = 1'b1;
        href       = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #2;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clean frame, first line with fixed bytes and no gaps
        start_frame();
        send_line(BPL, 0, 1);
        for (int i = 1; i < H; i++) send_line(BPL, 1, 0);
        check_flags();
        // Extra line after the frame closed
        send_line(BPL, 1, 0);
        check_flags();

        // Short line, long line, then truncated frame
        start_frame();
        send_line(BPL - 2, 1, 0);
        send_line(BPL + 4, 1, 0);
        check_flags();
        send_line(BPL, 1, 0);
        @(negedge clk);
        vsync = 1'b1;
        m_active = 0;
        idle(4);
        check_flags();

        // Frame with random line lengths around nominal
        start_frame();
        for (int i = 0; i < H; i++)
            send_line(BPL - 5 + int'($urandom_range(0, 10)), 1, 0);
        check_flags();

        // Reset two bytes into a word
        start_frame();
        send_line(BPL, 1, 0);
        repeat (2) begin
            @(negedge clk);
            href       = 1'b1;
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        href       = 1'b0;
        byte_valid = 1'b0;
        m_active   = 0;
        m_closed   = 0;
        exp_es     = 0;
        exp_el     = 0;
        check("queue_at_reset", 32'(q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_line(BPL, 1, 0);
        check_flags();

        // Capture resumes on the next frame
        start_frame();
        for (int i = 0; i < H; i++) send_line(BPL, 1, 0);
        idle(5);
        check_flags();
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
